wb_arbiter_2m: RTL and testbench

Shares one pipelined Wishbone B4 slave port between two Wishbone masters, for example an instruction fetch and a data load/store unit driving a single test slave. Arbitration is round-robin and locked per bus cycle: the grant is held while the granted master keeps cyc high. The block also limits outstanding (accepted but unacknowledged) requests per cycle. It sits between the masters under test and the instrumented slave in test harnesses.

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_outstanding_counter.sv | 44 ++++
 rtl/wb_arbiter_2m.sv | 161 ++++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone arbiter constants: bus widths and FSM state encodings.
package wb_pkg;

    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;

    // Arbiter FSM states
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StGrant0 = 2'd1;
    localparam logic [1:0] StGrant1 = 2'd2;

endpackage

// File: rtl/wb_outstanding_counter.sv
// Saturating up/down counter of accepted-but-unacknowledged requests, with a limit flag.
module wb_outstanding_counter #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic limit_o
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inc_ok, dec_ok;

    // Next count: clear wins; increments stop at the limit and an ack at zero is ignored
    always_comb begin
        inc_ok = inc_i & (cnt_q != MaxCnt);
        dec_ok = dec_i & (cnt_q != '0);
        cnt_d  = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_ok && !dec_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_ok && !inc_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign limit_o = (cnt_q == MaxCnt);

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin arbiter for one pipelined Wishbone B4 slave, locked per bus cycle,
// with a cap on outstanding requests.
module wb_arbiter_2m
    import wb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic [ADR_W-1:0] m0_wb_adr_i,
    input  logic [DAT_W-1:0] m0_wb_dat_i,
    output logic [DAT_W-1:0] m0_wb_dat_o,
    input  logic             m0_wb_we_i,
    input  logic [SEL_W-1:0] m0_wb_sel_i,
    input  logic             m0_wb_stb_i,
    input  logic             m0_wb_cyc_i,
    output logic             m0_wb_ack_o,
    output logic             m0_wb_stall_o,

    input  logic [ADR_W-1:0] m1_wb_adr_i,
    input  logic [DAT_W-1:0] m1_wb_dat_i,
    output logic [DAT_W-1:0] m1_wb_dat_o,
    input  logic             m1_wb_we_i,
    input  logic [SEL_W-1:0] m1_wb_sel_i,
    input  logic             m1_wb_stb_i,
    input  logic             m1_wb_cyc_i,
    output logic             m1_wb_ack_o,
    output logic             m1_wb_stall_o,

    output logic [ADR_W-1:0] s_wb_adr_o,
    output logic [DAT_W-1:0] s_wb_dat_o,
    output logic             s_wb_we_o,
    output logic [SEL_W-1:0] s_wb_sel_o,
    output logic             s_wb_stb_o,
    output logic             s_wb_cyc_o,
    input  logic [DAT_W-1:0] s_wb_dat_i,
    input  logic             s_wb_ack_i,
    input  logic             s_wb_stall_i,

    output logic [1:0]       grant_o
);

    logic [1:0] state_q, state_d;
    // 0: m0 was granted last, 1: m1 was granted last
    logic       last_grant_q, last_grant_d;
    logic       release_cyc;
    logic       limit;
    logic       accept;
    logic       cnt_clr;
    logic       cnt_dec;

    // Arbitration and release decisions
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        release_cyc  = 1'b0;
        case (state_q)
            StIdle: begin
                if (m0_wb_cyc_i && m1_wb_cyc_i) begin
                    state_d = last_grant_q ? StGrant0 : StGrant1;
                end else if (m0_wb_cyc_i) begin
                    state_d = StGrant0;
                end else if (m1_wb_cyc_i) begin
                    state_d = StGrant1;
                end
            end
            StGrant0: begin
                if (!m0_wb_cyc_i) begin
                    state_d      = StIdle;
                    last_grant_d = 1'b0;
                    release_cyc  = 1'b1;
                end
            end
            StGrant1: begin
                if (!m1_wb_cyc_i) begin
                    state_d      = StIdle;
                    last_grant_d = 1'b1;
                    release_cyc  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM and round-robin history registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Request/response routing for the granted master; the other master is held off
    always_comb begin
        s_wb_adr_o    = '0;
        s_wb_dat_o    = '0;
        s_wb_we_o     = 1'b0;
        s_wb_sel_o    = '0;
        s_wb_stb_o    = 1'b0;
        s_wb_cyc_o    = 1'b0;
        m0_wb_dat_o   = '0;
        m0_wb_ack_o   = 1'b0;
        m0_wb_stall_o = 1'b1;
        m1_wb_dat_o   = '0;
        m1_wb_ack_o   = 1'b0;
        m1_wb_stall_o = 1'b1;
        grant_o       = 2'b00;
        case (state_q)
            StGrant0: begin
                grant_o       = 2'b01;
                s_wb_adr_o    = m0_wb_adr_i;
                s_wb_dat_o    = m0_wb_dat_i;
                s_wb_we_o     = m0_wb_we_i;
                s_wb_sel_o    = m0_wb_sel_i;
                s_wb_cyc_o    = m0_wb_cyc_i;
                s_wb_stb_o    = m0_wb_stb_i & ~limit;
                m0_wb_stall_o = s_wb_stall_i | limit;
                m0_wb_ack_o   = s_wb_ack_i;
                m0_wb_dat_o   = s_wb_dat_i;
            end
            StGrant1: begin
                grant_o       = 2'b10;
                s_wb_adr_o    = m1_wb_adr_i;
                s_wb_dat_o    = m1_wb_dat_i;
                s_wb_we_o     = m1_wb_we_i;
                s_wb_sel_o    = m1_wb_sel_i;
                s_wb_cyc_o    = m1_wb_cyc_i;
                s_wb_stb_o    = m1_wb_stb_i & ~limit;
                m1_wb_stall_o = s_wb_stall_i | limit;
                m1_wb_ack_o   = s_wb_ack_i;
                m1_wb_dat_o   = s_wb_dat_i;
            end
            default: ;
        endcase
    end

    // Acks seen in IDLE belong to an aborted cycle and must not touch the count
    always_comb begin
        accept  = s_wb_stb_o & ~s_wb_stall_i;
        cnt_dec = s_wb_ack_i & (state_q != StIdle);
        cnt_clr = release_cyc | (state_q == StIdle);
    end

    wb_outstanding_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (cnt_clr),
        .inc_i   (accept),
        .dec_i   (cnt_dec),
        .limit_o (limit)
    );

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed self-checking bench for wb_arbiter_2m with a read-data scoreboard.
module tb_wb_arbiter_2m;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] m0_adr = '0, m0_wdat = '0, m1_adr = '0, m1_wdat = '0;
    logic [31:0] m0_rdat, m1_rdat;
    logic        m0_we = 1'b0, m1_we = 1'b0;
    logic [3:0]  m0_sel = 4'hF, m1_sel = 4'hF;
    logic        m0_stb = 1'b0, m0_cyc = 1'b0, m1_stb = 1'b0, m1_cyc = 1'b0;
    logic        m0_ack, m0_stall, m1_ack, m1_stall;
    logic [31:0] s_adr, s_wdat;
    logic        s_we, s_stb, s_cyc;
    logic [3:0]  s_sel;
    logic [31:0] s_rdat = '0;
    logic        s_ack = 1'b0, s_stall = 1'b0;
    logic [1:0]  grant;

    int          tests = 0;
    int          fails = 0;
    int          acc;
    logic [31:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    wb_arbiter_2m #(
        .MAX_OUTSTANDING (4),
        .CNT_W           (4)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .m0_wb_adr_i   (m0_adr),
        .m0_wb_dat_i   (m0_wdat),
        .m0_wb_dat_o   (m0_rdat),
        .m0_wb_we_i    (m0_we),
        .m0_wb_sel_i   (m0_sel),
        .m0_wb_stb_i   (m0_stb),
        .m0_wb_cyc_i   (m0_cyc),
        .m0_wb_ack_o   (m0_ack),
        .m0_wb_stall_o (m0_stall),
        .m1_wb_adr_i   (m1_adr),
        .m1_wb_dat_i   (m1_wdat),
        .m1_wb_dat_o   (m1_rdat),
        .m1_wb_we_i    (m1_we),
        .m1_wb_sel_i   (m1_sel),
        .m1_wb_stb_i   (m1_stb),
        .m1_wb_cyc_i   (m1_cyc),
        .m1_wb_ack_o   (m1_ack),
        .m1_wb_stall_o (m1_stall),
        .s_wb_adr_o    (s_adr),
        .s_wb_dat_o    (s_wdat),
        .s_wb_we_o     (s_we),
        .s_wb_sel_o    (s_sel),
        .s_wb_stb_o    (s_stb),
        .s_wb_cyc_o    (s_cyc),
        .s_wb_dat_i    (s_rdat),
        .s_wb_ack_i    (s_ack),
        .s_wb_stall_i  (s_stall),
        .grant_o       (grant)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare a returned read word against the oldest scoreboard entry
    task automatic sb_check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed %h expected <scoreboard entry>", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            chk(tag, obs, exp);
        end
    endtask

    // Count accepts over n cycles, sampling mid-cycle
    task automatic count_accepts(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            #1;
            if (s_stb && !s_stall) cnt++;
            tick();
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        // Reset values
        #3;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_cyc", 32'(s_cyc), 32'h0);
        chk("rst_stb", 32'(s_stb), 32'h0);
        chk("rst_acks", 32'({m0_ack, m1_ack}), 32'h0);
        chk("rst_stalls", 32'({m0_stall, m1_stall}), 32'h3);
        tick();
        rst_i = 1'b0;
        tick();

        // 1: single master read
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h100;
        #1;
        chk("t1_arb_latency_stb", 32'(s_stb), 32'h0);
        tick();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_adr", s_adr, 32'h100);
        chk("t1_stb", 32'(s_stb), 32'h1);
        exp_q.push_back(32'hDEADBEEF);
        tick();
        m0_stb = 1'b0; s_ack = 1'b1; s_rdat = 32'hDEADBEEF;
        #1;
        chk("t1_m0_ack", 32'(m0_ack), 32'h1);
        sb_check("t1_m0_dat", m0_rdat);
        chk("t1_m1_stall", 32'(m1_stall), 32'h1);
        chk("t1_m1_ack", 32'(m1_ack), 32'h0);
        chk("t1_m1_dat", m1_rdat, 32'h0);
        tick();
        s_ack = 1'b0; m0_cyc = 1'b0;
        tick();
        chk("t1_idle_grant", 32'(grant), 32'h0);

        // 2: contention right after reset, then round robin
        do_reset();
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        tick();
        chk("t2_first_m0", 32'(grant), 32'h1);
        m0_cyc = 1'b0;
        tick();
        chk("t2_idle_gap_grant", 32'(grant), 32'h0);
        chk("t2_idle_gap_cyc", 32'(s_cyc), 32'h0);
        tick();
        chk("t2_then_m1", 32'(grant), 32'h2);
        m1_cyc = 1'b0;
        tick();
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        tick();
        chk("t2_rr_m0", 32'(grant), 32'h1);
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        tick();
        tick();

        // 3: outstanding limit with a silent slave
        m0_cyc = 1'b1; m0_stb = 1'b1;
        tick();
        count_accepts(6, acc);
        chk("t3_accepts", 32'(acc), 32'd4);
        #1;
        chk("t3_stall_at_limit", 32'(m0_stall), 32'h1);
        chk("t3_stb_at_limit", 32'(s_stb), 32'h0);
        s_ack = 1'b1; s_rdat = 32'h0000_0003;
        exp_q.push_back(32'h0000_0003);
        #1;
        sb_check("t3_ack_dat", m0_rdat);
        tick();
        s_ack = 1'b0;
        count_accepts(3, acc);
        chk("t3_one_more", 32'(acc), 32'd1);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();
        tick();

        // 4: accept and ack coincide at outstanding=2
        m0_cyc = 1'b1; m0_stb = 1'b1;
        tick();
        tick();
        tick();
        s_ack = 1'b1; s_rdat = 32'hA5A5_0002;
        exp_q.push_back(32'hA5A5_0002);
        #1;
        chk("t4_ack", 32'(m0_ack), 32'h1);
        sb_check("t4_dat", m0_rdat);
        chk("t4_stall_free", 32'(m0_stall), 32'h0);
        chk("t4_stb", 32'(s_stb), 32'h1);
        tick();
        s_ack = 1'b0; s_stall = 1'b1;
        #1;
        chk("t4_stall_follows_slave", 32'(m0_stall), 32'h1);
        tick();
        s_stall = 1'b0;
        count_accepts(4, acc);
        chk("t4_room_left", 32'(acc), 32'd2);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();
        tick();

        // 5: m1 aborts with 3 outstanding while m0 waits
        m1_cyc = 1'b1; m1_stb = 1'b1;
        tick();
        m0_cyc = 1'b1;
        #1;
        chk("t5_grant_m1", 32'(grant), 32'h2);
        chk("t5_m0_held", 32'(m0_stall), 32'h1);
        tick();
        tick();
        tick();
        m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();
        chk("t5_idle_grant", 32'(grant), 32'h0);
        chk("t5_idle_cyc", 32'(s_cyc), 32'h0);
        s_ack = 1'b1; s_rdat = 32'h1234_5678;
        #1;
        chk("t5_late_ack", 32'({m0_ack, m1_ack}), 32'h0);
        chk("t5_late_dat0", m0_rdat, 32'h0);
        chk("t5_late_dat1", m1_rdat, 32'h0);
        tick();
        s_ack = 1'b0; m0_stb = 1'b1;
        chk("t5_grant_m0", 32'(grant), 32'h1);
        count_accepts(5, acc);
        chk("t5_cleared", 32'(acc), 32'd4);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();
        tick();

        // 6: asynchronous reset mid-burst
        m0_cyc = 1'b1; m0_stb = 1'b1;
        tick();
        tick();
        tick();
        #3;
        rst_i = 1'b1; s_ack = 1'b1; m1_cyc = 1'b1;
        #1;
        chk("t6_grant", 32'(grant), 32'h0);
        chk("t6_cyc", 32'(s_cyc), 32'h0);
        chk("t6_stalls", 32'({m0_stall, m1_stall}), 32'h3);
        chk("t6_acks", 32'({m0_ack, m1_ack}), 32'h0);
        tick();
        rst_i = 1'b0; s_ack = 1'b0;
        tick();
        chk("t6_m0_first", 32'(grant), 32'h1);
        chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
